// File: rtl/inst_fetch_xlate_pkg.sv
// Shared fetch/data-side address-stage definitions: exception codes, segment decode, FSM states.
package inst_fetch_xlate_pkg;
  localparam int unsigned VA_W  = 32;
  localparam int unsigned PFN_W = 20;
  localparam int unsigned OFF_W = 12;
  localparam int unsigned EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXC_W-1:0] EXC_TLBL = 5'h02;

  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XLATE,
    ST_REQ,
    ST_EXC
  } fetch_state_t;

  typedef struct packed {
    logic [EXC_W-1:0] code;
    logic             refill;
    logic [VA_W-1:0]  badvaddr;
  } exc_info_t;
endpackage

// File: rtl/inst_fetch_xlate_if.sv
// Fetch-stage bus bundle: PC generator, micro-TLB, icache request and exception channels.
interface inst_fetch_xlate_if;
  import inst_fetch_xlate_pkg::*;

  logic             pc_valid;
  logic [VA_W-1:0]  pc_va;
  logic             pc_ready;
  logic             flush;
  logic [VA_W-1:0]  inst_VA;
  logic             inst_use_tlb;
  logic             inst_tlb_req_en;
  logic             inst_tlb_found;
  logic             inst_tlb_v;
  logic [PFN_W-1:0] inst_pfn;
  logic             inst_tlb_exception;
  logic             inst_req;
  logic [VA_W-1:0]  inst_addr;
  logic             inst_cached;
  logic             inst_addr_ok;
  logic             issued;
  logic             issued_stale;
  logic             exc_valid;
  logic [EXC_W-1:0] exc_code;
  logic             exc_refill;
  logic [VA_W-1:0]  exc_badvaddr;
  logic             exc_ack;

  // Fetch stage side
  modport master (
    input  pc_valid, pc_va, flush, inst_tlb_req_en, inst_tlb_found, inst_tlb_v,
           inst_pfn, inst_addr_ok, exc_ack,
    output pc_ready, inst_VA, inst_use_tlb, inst_tlb_exception, inst_req, inst_addr,
           inst_cached, issued, issued_stale, exc_valid, exc_code, exc_refill, exc_badvaddr
  );

  // Surrounding pipeline / TLB / icache side
  modport slave (
    output pc_valid, pc_va, flush, inst_tlb_req_en, inst_tlb_found, inst_tlb_v,
           inst_pfn, inst_addr_ok, exc_ack,
    input  pc_ready, inst_VA, inst_use_tlb, inst_tlb_exception, inst_req, inst_addr,
           inst_cached, issued, issued_stale, exc_valid, exc_code, exc_refill, exc_badvaddr
  );
endinterface

// File: rtl/inst_fetch_xlate_va_classify.sv
// Combinational VA classifier: alignment, kseg0/kseg1 detection and unmapped physical address.
module va_classify
  import inst_fetch_xlate_pkg::*;
#(
  parameter bit K0_CACHED = 1'b1
) (
  input  logic [VA_W-1:0] i_va,
  output logic            o_misaligned,
  output logic            o_unmapped,
  output logic            o_cached,
  output logic [VA_W-1:0] o_pa_unmapped
);
  logic [2:0] w_seg;

  assign w_seg         = i_va[VA_W-1:VA_W-3];
  assign o_misaligned  = (i_va[1:0] != 2'b00);
  assign o_unmapped    = (w_seg == SEG_KSEG0) || (w_seg == SEG_KSEG1);
  // kseg1 is always uncached; kseg0 follows the build-time choice
  assign o_cached      = (w_seg == SEG_KSEG1) ? 1'b0 : K0_CACHED;
  assign o_pa_unmapped = {3'b000, i_va[VA_W-4:0]};
endmodule

// File: rtl/inst_fetch_xlate.sv
// Fetch address stage: holds one VA, walks it through the micro-TLB and issues the icache request.
module inst_fetch_xlate
  import inst_fetch_xlate_pkg::*;
#(
  parameter bit K0_CACHED = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  inst_fetch_xlate_if.master bus
);
  fetch_state_t    r_state;
  logic [VA_W-1:0] r_va_q;
  logic [VA_W-1:0] r_pa_q;
  logic            r_cached_q;
  logic            r_cancel;
  exc_info_t       r_exc;

  logic            w_misaligned;
  logic            w_unmapped;
  logic            w_cached_unm;
  logic [VA_W-1:0] w_pa_unm;
  logic            w_xlate;
  logic            w_req;
  logic            w_cancel_now;
  logic            w_tlb_ok;

  va_classify #(.K0_CACHED(K0_CACHED)) u_classify (
    .i_va          (r_va_q),
    .o_misaligned  (w_misaligned),
    .o_unmapped    (w_unmapped),
    .o_cached      (w_cached_unm),
    .o_pa_unmapped (w_pa_unm)
  );

  assign w_xlate      = (r_state == ST_XLATE);
  assign w_req        = (r_state == ST_REQ);
  assign w_cancel_now = r_cancel | bus.flush;
  assign w_tlb_ok     = bus.inst_tlb_found & bus.inst_tlb_v;

  assign bus.pc_ready     = (r_state == ST_IDLE) & ~bus.flush;
  assign bus.inst_VA      = r_va_q;
  assign bus.inst_use_tlb = w_xlate & ~w_misaligned & ~w_unmapped;
  // Abort pulse whenever XLATE leaves without issuing a request
  assign bus.inst_tlb_exception = w_xlate & bus.inst_tlb_req_en &
                                  (w_cancel_now | w_misaligned | (~w_unmapped & ~w_tlb_ok));

  assign bus.inst_req     = w_req;
  assign bus.inst_addr    = r_pa_q;
  assign bus.inst_cached  = r_cached_q;
  assign bus.issued       = w_req & bus.inst_addr_ok;
  assign bus.issued_stale = w_req & bus.inst_addr_ok & w_cancel_now;

  assign bus.exc_valid    = (r_state == ST_EXC);
  assign bus.exc_code     = r_exc.code;
  assign bus.exc_refill   = r_exc.refill;
  assign bus.exc_badvaddr = r_exc.badvaddr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_va_q     <= '0;
      r_pa_q     <= '0;
      r_cached_q <= 1'b0;
      r_cancel   <= 1'b0;
      r_exc      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.pc_valid && bus.pc_ready) begin
            r_va_q  <= bus.pc_va;
            r_state <= ST_XLATE;
          end
        end
        ST_XLATE: begin
          if (!bus.inst_tlb_req_en) begin
            if (bus.flush) r_cancel <= 1'b1;
          end else if (w_cancel_now) begin
            r_cancel <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_misaligned) begin
            r_exc   <= '{code: EXC_ADEL, refill: 1'b0, badvaddr: r_va_q};
            r_state <= ST_EXC;
          end else if (!w_unmapped && !bus.inst_tlb_found) begin
            r_exc   <= '{code: EXC_TLBL, refill: 1'b1, badvaddr: r_va_q};
            r_state <= ST_EXC;
          end else if (!w_unmapped && !bus.inst_tlb_v) begin
            r_exc   <= '{code: EXC_TLBL, refill: 1'b0, badvaddr: r_va_q};
            r_state <= ST_EXC;
          end else begin
            r_pa_q     <= w_unmapped ? w_pa_unm : {bus.inst_pfn, r_va_q[OFF_W-1:0]};
            r_cached_q <= w_unmapped ? w_cached_unm : 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request stays up once raised; a flush only marks the returning data stale
          if (bus.inst_addr_ok) begin
            r_cancel <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (bus.flush) begin
            r_cancel <= 1'b1;
          end
        end
        ST_EXC: begin
          if (bus.exc_ack || bus.flush) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
